divider_32by16_seq: RTL and testbench



---
 rtl/divider_32by16_seq_if.sv | 23 ++
 rtl/divider_32by16_seq.sv | 124 ++++++++++++
 tb/tb_divider_32by16_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_32by16_seq_if.sv
// Handshake and result bundle for the 32/16 sequential divider.
// The master drives the request; the slave (the divider) returns results and flags.
interface divider_32by16_seq_if;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/divider_32by16_seq.sv
// Restoring 32/16 divider: one 17-bit compare/subtract per clock, 16 iterations,
// with a one-cycle error path for divide-by-zero and quotient overflow.
module divider_32by16_seq (
    input  logic                 clk,
    input  logic                 rst_n,
    divider_32by16_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [16:0] r_reg, r_next;
    logic [15:0] q_reg, q_next;
    logic [15:0] d_reg, d_next;
    logic        pend_dbz_reg, pend_dbz_next;
    logic        done_reg, done_next;
    logic [15:0] quot_reg, quot_next;
    logic [15:0] rem_reg, rem_next;
    logic        dbz_reg, dbz_next;
    logic        ov_reg, ov_next;

    logic [16:0] t;
    logic [16:0] diff;
    logic        borrow;
    logic [16:0] r_iter;
    logic        r_msb_unused;

    // R stays below D after every iteration, so its MSB never feeds the next trial value.
    assign r_msb_unused     = r_reg[16];
    assign t                = {r_reg[15:0], q_reg[15]};
    assign {borrow, diff}   = {1'b0, t} - {2'b00, d_reg};
    assign r_iter           = borrow ? t : diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            r_reg        <= 17'd0;
            q_reg        <= 16'd0;
            d_reg        <= 16'd0;
            pend_dbz_reg <= 1'b0;
            done_reg     <= 1'b0;
            quot_reg     <= 16'd0;
            rem_reg      <= 16'd0;
            dbz_reg      <= 1'b0;
            ov_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            r_reg        <= r_next;
            q_reg        <= q_next;
            d_reg        <= d_next;
            pend_dbz_reg <= pend_dbz_next;
            done_reg     <= done_next;
            quot_reg     <= quot_next;
            rem_reg      <= rem_next;
            dbz_reg      <= dbz_next;
            ov_reg       <= ov_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        r_next        = r_reg;
        q_next        = q_reg;
        d_next        = d_reg;
        pend_dbz_next = pend_dbz_reg;
        done_next     = 1'b0;
        quot_next     = quot_reg;
        rem_next      = rem_reg;
        dbz_next      = dbz_reg;
        ov_next       = ov_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    d_next   = bus.divisor;
                    r_next   = {1'b0, bus.dividend[31:16]};
                    q_next   = bus.dividend[15:0];
                    cnt_next = 4'd0;
                    dbz_next = 1'b0;
                    ov_next  = 1'b0;
                    if (bus.divisor == 16'd0) begin
                        pend_dbz_next = 1'b1;
                        state_next    = FIN;
                    end else if (bus.dividend[31:16] >= bus.divisor) begin
                        pend_dbz_next = 1'b0;
                        state_next    = FIN;
                    end else begin
                        state_next    = RUN;
                    end
                end
            end
            RUN: begin
                r_next   = r_iter;
                q_next   = {q_reg[14:0], ~borrow};
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == 4'd15) begin
                    quot_next  = {q_reg[14:0], ~borrow};
                    rem_next   = r_iter[15:0];
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            FIN: begin
                quot_next  = 16'hFFFF;
                rem_next   = 16'h0000;
                dbz_next   = pend_dbz_reg;
                ov_next    = ~pend_dbz_reg;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = done_reg;
    assign bus.quotient    = quot_reg;
    assign bus.remainder   = rem_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.overflow    = ov_reg;
endmodule

// File: tb/tb_divider_32by16_seq.sv
// Bench for the 32/16 sequential divider: directed vector table, hand-written
// protocol/reset sequences, and randomised operands against an arithmetic model.
module tb_divider_32by16_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    divider_32by16_seq_if bus();

    divider_32by16_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [15:0] last_q = 16'd0;
    logic [15:0] last_r = 16'd0;

    typedef struct {
        logic [31:0] n;
        logic [15:0] d;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division; a quotient that cannot fit 16 bits is overflow.
    task automatic model(input logic [31:0] n, input logic [15:0] d,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dbz, output logic ov, output int lat);
        logic [31:0] qq;
        dbz = 1'b0; ov = 1'b0; q = 16'hFFFF; r = 16'h0000; lat = 1;
        if (d == 16'd0) begin
            dbz = 1'b1;
        end else begin
            qq = n / {16'd0, d};
            if (qq > 32'h0000_FFFF) begin
                ov = 1'b1;
            end else begin
                q   = qq[15:0];
                r   = 16'(n % {16'd0, d});
                lat = 16;
            end
        end
    endtask

    // Waits for done after an accepted start; lat stays 0 if the bound expires.
    task automatic wait_done(output int lat);
        int bad;
        bad = 0;
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (bus.done) lat = i;
            else if (!bus.busy) bad++;
        end
        check("busy_until_done", bad, 0);
        check("done_busy_exclusive", bus.busy, 0);
    endtask

    task automatic apply(input string tag, input logic [31:0] n, input logic [15:0] d,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic edbz, input logic eov, input int elat);
        int lat;
        bus.dividend = n;
        bus.divisor  = d;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_on_accept", bus.busy, 1);
        check("flags_clear_on_accept", {bus.div_by_zero, bus.overflow}, 0);
        check("quotient_held_on_accept", bus.quotient, last_q);
        check("remainder_held_on_accept", bus.remainder, last_r);
        wait_done(lat);
        $display("[TB] %s n=%08h d=%04h q=%04h r=%04h dbz=%0b ov=%0b lat=%0d",
                 tag, n, d, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow, lat);
        check("latency", lat, elat);
        check("quotient", bus.quotient, eq);
        check("remainder", bus.remainder, er);
        check("div_by_zero", bus.div_by_zero, edbz);
        check("overflow", bus.overflow, eov);
        last_q = eq;
        last_r = er;
        @(posedge clk); #1;
        check("done_one_cycle", bus.done, 0);
        check("quotient_held_after", bus.quotient, eq);
        check("flags_held_after", {bus.div_by_zero, bus.overflow}, {edbz, eov});
    endtask

    // Every cycle: busy and done must never overlap.
    always @(negedge clk) begin
        tests++;
        if (bus.busy && bus.done) begin
            fails++;
            $display("FAIL busy_done_overlap: got busy=1 done=1, expected not both");
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [15:0] mq, mr;
        logic        mdbz, mov;
        int          mlat, lat;
        logic [31:0] a, b, rr, n;
        logic [15:0] d;

        tbl[0] = '{32'd100,       16'd7,      16'd14,     16'd2,      1'b0, 1'b0, 16};
        tbl[1] = '{32'hFFFE_0001, 16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 1'b0, 16};
        tbl[2] = '{32'h1234_5678, 16'd0,      16'hFFFF,   16'h0000,   1'b1, 1'b0, 1};
        tbl[3] = '{32'h0007_0000, 16'd7,      16'hFFFF,   16'h0000,   1'b0, 1'b1, 1};
        tbl[4] = '{32'h0006_FFFF, 16'd7,      16'hFFFF,   16'd6,      1'b0, 1'b0, 16};
        tbl[5] = '{32'd1,         16'd1,      16'd1,      16'd0,      1'b0, 1'b0, 16};
        tbl[6] = '{32'd0,         16'd5,      16'd0,      16'd0,      1'b0, 1'b0, 16};
        tbl[7] = '{32'h0000_FFFF, 16'd1,      16'hFFFF,   16'd0,      1'b0, 1'b0, 16};
        tbl[8] = '{32'h0001_0000, 16'd1,      16'hFFFF,   16'd0,      1'b0, 1'b1, 1};
        tbl[9] = '{32'h7FFF_FFFF, 16'h8000,   16'hFFFF,   16'h7FFF,   1'b0, 1'b0, 16};

        bus.start = 1'b0; bus.dividend = 32'd0; bus.divisor = 16'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_quotient", bus.quotient, 0);
        check("reset_remainder", bus.remainder, 0);
        check("reset_flags", {bus.div_by_zero, bus.overflow}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            apply($sformatf("vec%0d", i), tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].r,
                  tbl[i].dbz, tbl[i].ov, tbl[i].lat);

        // Start pulse with other operands in the middle of a run must be ignored.
        bus.dividend = 32'd100000; bus.divisor = 16'd300; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("ignore_quotient_held", bus.quotient, last_q);
        bus.dividend = 32'h0000_0010; bus.divisor = 16'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat);
        $display("[TB] ignore-start q=%04h r=%04h lat=%0d", bus.quotient, bus.remainder, lat + 5);
        check("ignore_latency", lat + 5, 16);
        check("ignore_quotient", bus.quotient, 16'd333);
        check("ignore_remainder", bus.remainder, 16'd100);
        last_q = 16'd333; last_r = 16'd100;
        @(posedge clk); #1;

        // Reset at iteration 8 aborts without a done.
        bus.dividend = 32'd500000; bus.divisor = 16'd9; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", bus.busy, 0);
        check("midreset_done", bus.done, 0);
        check("midreset_quotient", bus.quotient, 0);
        check("midreset_remainder", bus.remainder, 0);
        check("midreset_flags", {bus.div_by_zero, bus.overflow}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("no_done_after_reset", bus.done, 0);
        end
        $display("[TB] mid-run reset applied and released");
        last_q = 16'd0; last_r = 16'd0;
        apply("after-reset", 32'd500000, 16'd9, 16'd55555, 16'd5, 1'b0, 1'b0, 16);

        // start held high: the next operation is accepted in the done cycle.
        bus.dividend = 32'h0006_FFFF; bus.divisor = 16'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.dividend = 32'd100; bus.divisor = 16'd7;
        wait_done(lat);
        $display("[TB] held-start A q=%04h r=%04h lat=%0d", bus.quotient, bus.remainder, lat);
        check("held_a_latency", lat, 16);
        check("held_a_quotient", bus.quotient, 16'hFFFF);
        check("held_a_remainder", bus.remainder, 16'd6);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("held_b_accepted", bus.busy, 1);
        check("held_b_done_low", bus.done, 0);
        wait_done(lat);
        $display("[TB] held-start B q=%04h r=%04h lat=%0d", bus.quotient, bus.remainder, lat);
        check("held_b_latency", lat, 16);
        check("held_b_quotient", bus.quotient, 16'd14);
        check("held_b_remainder", bus.remainder, 16'd2);
        @(posedge clk); #1;

        // Back-to-back error operations, one per cycle of start.
        bus.dividend = 32'h1234_5678; bus.divisor = 16'd0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.dividend = 32'h0007_0000; bus.divisor = 16'd7;
        @(posedge clk); #1;
        check("b2b_dbz_done", bus.done, 1);
        check("b2b_dbz_flag", bus.div_by_zero, 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_dbz_cleared", bus.div_by_zero, 0);
        check("b2b_busy", bus.busy, 1);
        @(posedge clk); #1;
        check("b2b_ov_done", bus.done, 1);
        check("b2b_ov_flag", bus.overflow, 1);
        $display("[TB] back-to-back errors dbz then ovf q=%04h", bus.quotient);
        last_q = 16'hFFFF; last_r = 16'h0000;
        @(posedge clk); #1;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                n = $urandom;
                d = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
                model(n, d, mq, mr, mdbz, mov, mlat);
                apply("rand-any", n, d, mq, mr, mdbz, mov, mlat);
            end else begin
                a  = $urandom_range(1, 65535);
                b  = $urandom_range(1, 65535);
                rr = $urandom_range(0, b - 1);
                n  = a * b + rr;
                apply("rand-inv", n, b[15:0], a[15:0], rr[15:0], 1'b0, 1'b0, 16);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
